branch_resolve_queue: RTL and testbench

//  Sits directly downstream of the 2-bit branch predictor. Captures each prediction (p_taken) issued at fetch
//  and holds it in program order until the branch resolves. Compares it with the actual outcome and raises
//  a mispredict/flush. Drives the resolved outcome back to the predictor's taken input, and keeps hit/miss statistics.

---
 rtl/bp_pkg.sv | 12 +
 rtl/branch_resolve_queue_if.sv | 19 +
 rtl/bp_fifo.sv | 55 +++++
 rtl/branch_resolve_queue.sv | 65 ++++++
 tb/tb_branch_resolve_queue.sv | 139 +++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared sizing defaults and 2-bit predictor state encodings
package bp_pkg;
  localparam int BP_DEPTH = 4;
  localparam int BP_PTR_W = 2;
  localparam int BP_CNT_W = 16;
  typedef enum logic [1:0] {
    ST_STRONG_NT = 2'b00,
    ST_WEAK_NT   = 2'b01,
    ST_WEAK_T    = 2'b10,
    ST_STRONG_T  = 2'b11
  } bp_state_e;
endpackage

// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: fetch/resolve handshake and status bundle
interface branch_resolve_queue_if import bp_pkg::*; #(
  parameter int PTR_W = BP_PTR_W,
  parameter int CNT_W = BP_CNT_W
);
  logic pred_valid, p_taken, pred_ready;
  logic res_valid, res_taken;
  logic upd_valid, taken_o, mispredict, err_underflow;
  logic [PTR_W:0] count;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;
  modport master(
    output pred_valid, p_taken, res_valid, res_taken,
    input pred_ready, upd_valid, taken_o, mispredict, err_underflow, count, hit_cnt, miss_cnt
  );
  modport slave(
    input pred_valid, p_taken, res_valid, res_taken,
    output pred_ready, upd_valid, taken_o, mispredict, err_underflow, count, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/bp_fifo.sv
// bp_fifo: 1-bit synchronous FIFO with flush; flush wins over push/pop
module bp_fifo import bp_pkg::*; #(
  parameter int DEPTH = BP_DEPTH,
  parameter int PTR_W = BP_PTR_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           din,
  input  logic           pop,
  input  logic           flush,
  output logic           head,
  output logic [PTR_W:0] count,
  output logic           full,
  output logic           empty
);
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count_q, count_d;
  logic do_push, do_pop;
  assign full = count_q == (PTR_W+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign head = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_comb begin
    mem_d = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d = '0;
    end else begin
      if (do_push) mem_d[wr_ptr_q] = din;
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: holds predictions in order, compares at resolve, flushes on mispredict
module branch_resolve_queue import bp_pkg::*; #(
  parameter int DEPTH = BP_DEPTH,
  parameter int PTR_W = BP_PTR_W,
  parameter int CNT_W = BP_CNT_W
) (
  input logic clk,
  input logic rst,
  branch_resolve_queue_if.slave bus
);
  logic head, full, empty, pop, hit, miss;
  logic [PTR_W:0] fifo_count;
  logic upd_valid_q, upd_valid_d, taken_o_q, taken_o_d;
  logic mispredict_q, mispredict_d, err_q, err_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  assign pop = bus.res_valid && !empty;
  assign miss = pop && (head != bus.res_taken);
  assign hit = pop && !miss;
  // a push in the mispredicting cycle is wrong-path and is dropped
  bp_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(bus.pred_valid && !miss),
    .din(bus.p_taken),
    .pop(pop),
    .flush(miss),
    .head(head),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    upd_valid_d = pop;
    taken_o_d = pop ? bus.res_taken : taken_o_q;
    mispredict_d = miss;
    err_d = err_q || (bus.res_valid && empty);
    hit_cnt_d = (hit && !(&hit_cnt_q)) ? hit_cnt_q + 1'b1 : hit_cnt_q;
    miss_cnt_d = (miss && !(&miss_cnt_q)) ? miss_cnt_q + 1'b1 : miss_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid_q <= 1'b0;
      taken_o_q <= 1'b0;
      mispredict_q <= 1'b0;
      err_q <= 1'b0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      upd_valid_q <= upd_valid_d;
      taken_o_q <= taken_o_d;
      mispredict_q <= mispredict_d;
      err_q <= err_d;
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
  assign bus.pred_ready = !full;
  assign bus.count = fifo_count;
  assign bus.upd_valid = upd_valid_q;
  assign bus.taken_o = taken_o_q;
  assign bus.mispredict = mispredict_q;
  assign bus.err_underflow = err_q;
  assign bus.hit_cnt = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: cycle model plus result scoreboard for branch_resolve_queue
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  typedef struct packed {logic t; logic m;} res_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  bit mq[$];
  res_t sb[$];
  int hitm = 0, missm = 0;
  bit errm = 0, lastt = 0, exp_upd = 0;
  always #5 clk = ~clk;
  branch_resolve_queue_if bus();
  branch_resolve_queue dut(.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit pv, input bit pt, input bit rv, input bit rt);
    bit pop, miss, ready;
    res_t r;
    bus.pred_valid = pv;
    bus.p_taken = pt;
    bus.res_valid = rv;
    bus.res_taken = rt;
    ready = mq.size() != DEPTH;
    pop = rv && mq.size() != 0;
    miss = pop && (mq[0] != rt);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      sb.delete();
      hitm = 0;
      missm = 0;
      errm = 0;
      lastt = 0;
      exp_upd = 0;
    end else begin
      if (rv && mq.size() == 0) errm = 1;
      if (pop) begin
        r.t = rt;
        r.m = miss;
        sb.push_back(r);
        void'(mq.pop_front());
        lastt = rt;
        if (miss) begin
          missm++;
          mq.delete();
        end else hitm++;
      end
      if (pv && ready && !miss) mq.push_back(pt);
      exp_upd = pop;
    end
    #1;
    chk("upd_valid", bus.upd_valid, exp_upd);
    if (exp_upd && sb.size() != 0) begin
      r = sb.pop_front();
      chk("taken_o", bus.taken_o, r.t);
      chk("mispredict", bus.mispredict, r.m);
    end else begin
      chk("taken_hold", bus.taken_o, lastt);
      chk("mispredict_idle", bus.mispredict, 0);
    end
    chk("count", bus.count, mq.size());
    chk("pred_ready", bus.pred_ready, mq.size() != DEPTH);
    chk("hit_cnt", bus.hit_cnt, hitm);
    chk("miss_cnt", bus.miss_cnt, missm);
    chk("err_underflow", bus.err_underflow, errm);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
  endtask
  task automatic correct(input bit pv, input bit pt);
    step(pv, pt, 1, mq.size() != 0 ? mq[0] : 1'b0);
  endtask
  initial begin
    bus.pred_valid = 0;
    bus.p_taken = 0;
    bus.res_valid = 0;
    bus.res_taken = 0;
    do_reset();
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("t1_count3", bus.count, 3);
    step(1, 0, 0, 0);
    chk("t1_full_ready", bus.pred_ready, 0);
    step(1, 1, 0, 0);
    chk("t1_count_stays4", bus.count, 4);
    do_reset();
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    chk("t2_hit", bus.hit_cnt, 1);
    chk("t2_count1", bus.count, 1);
    do_reset();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    chk("t3_mispredict", bus.mispredict, 1);
    chk("t3_count0", bus.count, 0);
    do_reset();
    step(0, 0, 1, 1);
    chk("t4_err", bus.err_underflow, 1);
    step(1, 1, 0, 0);
    correct(1, 0);
    correct(0, 0);
    chk("t4_err_sticky", bus.err_underflow, 1);
    do_reset();
    chk("t4_err_cleared", bus.err_underflow, 0);
    for (int i = 0; i < DEPTH; i++) step(1, i[0], 0, 0);
    for (int i = 0; i < DEPTH * 3; i++) correct(1, 1'($urandom));
    chk("t5_no_miss", bus.miss_cnt, 0);
    for (int i = 0; i < 300; i++) begin
      if (mq.size() != 0 && $urandom_range(0, 3) != 0)
        correct($urandom_range(0, 2) != 0, 1'($urandom));
      else
        step($urandom_range(0, 2) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    do_reset();
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    correct(1, 1);
    step(1, 1, 0, 0);
    chk("t6_pre_count3", bus.count, 3);
    do_reset();
    chk("t6_count0", bus.count, 0);
    chk("t6_hit0", bus.hit_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
